key_compositor: RTL and testbench
=================================

# key_compositor

Pipelined background compositor that sits downstream of the green-screen keyer in the pixel path. It recognises keyed pixels (RGB forced to 0x000000 by the keyer) and substitutes a generated background pixel. A pixel is substituted only when it belongs to a horizontal run of at least MIN_RUN keyed pixels; shorter runs (isolated dark speckle) pass through unchanged. It also reports the per-frame count of substituted pixels.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- MIN_RUN, 4, minimum keyed run length that gets replaced; legal range 2..15
- TILE_LOG2, 5, checkerboard tile size is 2^TILE_LOG2 pixels
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- comp_en  in  1  compositing enable; sampled per pixel together with vld_in
- r, g, b  in  8 each  keyer output pixel
- vld_in  in  1  pixel valid
- sof  in  1  start of frame; qualified by vld_in and marks pixel (0,0)
- bg_mode  in  2  background source: 0 solid, 1 checkerboard, 2 gradient, 3 no substitution
- bg_color  in  24  {R,G,B} base colour
- pass_in  in  24  sideband; delayed with the pixel
- outR, outG, outB  out  8 each  composited pixel
- vld_out, sof_out  out  1 each  delayed vld_in and sof
- pass_thru  out  24  delayed pass_in
- key_count  out  20  number of substituted pixels in the previous frame
- key_count_vld  out  1  one-cycle pulse when key_count updates

## Operation
- Key flag: vld_in & comp_en & ({r,g,b}==0) & (bg_mode!=3).
- x/y counters advance only on vld_in. sof&vld_in sets that pixel to x=0, y=0.
  - x wraps from H_ACTIVE-1 to 0, and y increments on that wrap.
  - y saturates at V_ACTIVE-1.
- Background value is computed at input time from the pixel's x/y and carried with it.
  - mode 0: bg_color.
  - mode 1: bg_color when x[TILE_LOG2]^y[TILE_LOG2]==0, else ~bg_color.
  - mode 2: R=x[9:2], G=y[8:1], B=bg_color[7:0].
- Delay line of MIN_RUN stages. Each stage holds pixel, vld, sof, pass, bg and a replace bit.
- Run counter (4 bits, saturating at MIN_RUN) increments on each keyed pixel.
  - Resets to 0 on: a non-keyed valid pixel, vld_in low, sof, or x==0 (new line).
  - When the run reaches MIN_RUN, the entering pixel and the MIN_RUN-1 keyed pixels already in the line all get replace=1.
  - While the run stays at MIN_RUN, each further keyed pixel enters with replace=1.
- Output stage: if replace=1, the output is bg; otherwise it is the original pixel. Runs shorter than MIN_RUN, including runs cut by a line end, are never replaced.
- key_count accumulator counts output pixels with replace=1, saturating at 2^20-1.
  - On an output pixel with sof_out, the previous total is latched into key_count and key_count_vld pulses.
  - The accumulator then restarts at 0, or at 1 if that pixel is itself replaced.

## Timing
- Fixed latency: inputs presented in cycle n appear on the outputs in cycle n+MIN_RUN+1. This holds for vld, sof, pass and pixel. The pipeline advances every clock; gaps travel as vld=0.
- All outputs are registered.
- Reset values: outR/outG/outB=0, vld_out=0, sof_out=0, pass_thru=0, key_count=0, key_count_vld=0. Pipeline, run counter, x, y and the accumulator are all 0.
- Reset mid-frame discards in-flight pixels. vld_out stays 0 for MIN_RUN+1 cycles after rst deasserts unless new valid input arrives.
- sof while a run is in progress: the run is broken, and that pixel starts a new run.
- comp_en and bg_mode changes take effect on the next pixel entering; no frame alignment.
- sof with vld_in low is ignored.

## Test plan
- MIN_RUN=4, H_ACTIVE=8, bg_mode=0, bg_color=0x123456. Line of 0,0,0,0,0,X,X,X (X nonzero) -> first five outputs 0x123456, last three X, latency 5 cycles.
- Line 0,0,0,X,0,0,X,X -> all eight output unchanged, including the black pixels; key_count for the frame = 0.
- Run crossing a line end (x=5..7 black, then next line x=0..1 black) -> no substitution, since both fragments are shorter than 4.
- bg_mode=1, TILE_LOG2=1, full 8x4 black frame -> output alternates bg_color/~bg_color every 2 pixels and flips every 2 lines. The next sof_out pulses key_count_vld with key_count=32.
- comp_en=0 mid-frame, or bg_mode=3 -> outputs equal inputs delayed 5 cycles; pass_thru tracks pass_in.
- rst asserted mid-run -> all outputs 0 on the next edge. After release, the first sof frame behaves normally and key_count=0 until its first sof_out.

Source files
------------

// File: rtl/key_compositor.sv
// rtl/key_compositor.sv - keyed-pixel background compositor with minimum-run filtering
//
// Replaces keyed (all-zero RGB) pixels with a generated background, but only
// when they belong to a horizontal run of at least MIN_RUN keyed pixels.
// Shorter runs pass through. Counts substituted pixels per frame.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   comp_en             compositing enable, sampled with each pixel
//   r, g, b, vld_in     keyer output pixel and its valid
//   sof                 start of frame, qualified by vld_in, marks pixel (0,0)
//   bg_mode, bg_color   background source (solid/checker/gradient/off) and base colour
//   pass_in             24-bit sideband carried alongside the pixel
//   outR, outG, outB    composited pixel, MIN_RUN+1 cycles after input
//   vld_out, sof_out    delayed vld_in and sof
//   pass_thru           delayed pass_in
//   key_count(_vld)     previous frame's substituted-pixel count and its update pulse
module key_compositor #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_RUN   = 4,
  parameter int TILE_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        comp_en,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        vld_in,
  input  logic        sof,
  input  logic [1:0]  bg_mode,
  input  logic [23:0] bg_color,
  input  logic [23:0] pass_in,
  output logic [7:0]  outR,
  output logic [7:0]  outG,
  output logic [7:0]  outB,
  output logic        vld_out,
  output logic        sof_out,
  output logic [23:0] pass_thru,
  output logic [19:0] key_count,
  output logic        key_count_vld
);

  // Counters are at least as wide as the gradient mode's bit selects need.
  localparam int XW = ($clog2(H_ACTIVE) > 10) ? $clog2(H_ACTIVE) : 10;
  localparam int YW = ($clog2(V_ACTIVE) > 9) ? $clog2(V_ACTIVE) : 9;
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [3:0]    RUN_MAX  = 4'(MIN_RUN);
  localparam logic [3:0]    RUN_TRIG = 4'(MIN_RUN - 1);

  typedef struct packed {
    logic        vld;
    logic        sof;
    logic [23:0] pix;
    logic [23:0] pass;
    logic [23:0] bg;
  } stage_t;

  stage_t             pipe [MIN_RUN];
  stage_t             head;
  stage_t             tail;
  logic [MIN_RUN-1:0] rep_q;      // bit i is the replace flag of pipe[i]
  logic               head_rep;
  logic               tail_rep;
  logic               first;
  logic               key;
  logic               trig;
  logic [XW-1:0]      x_cnt;
  logic [XW-1:0]      cur_x;
  logic [YW-1:0]      y_cnt;
  logic [YW-1:0]      cur_y;
  logic [3:0]         run_cnt;
  logic [3:0]         run_base;
  logic [3:0]         run_next;
  logic [23:0]        bg_val;
  logic [19:0]        acc;

  always_comb begin
    first    = sof & vld_in;
    cur_x    = first ? '0 : x_cnt;
    cur_y    = first ? '0 : y_cnt;
    key      = vld_in & comp_en & ({r, g, b} == 24'd0) & (bg_mode != 2'd3);
    // A new frame or a new line always starts a fresh run.
    run_base = (first || cur_x == '0) ? 4'd0 : run_cnt;
    run_next = 4'd0;
    if (key) begin
      run_next = (run_base == RUN_MAX) ? RUN_MAX : run_base + 4'd1;
    end
    // The pixel that completes a run back-marks the MIN_RUN-1 keyed pixels
    // already sitting in the delay line.
    trig     = key & (run_base == RUN_TRIG);
    head_rep = key & (run_next == RUN_MAX);
    case (bg_mode)
      2'd1:    bg_val = (cur_x[TILE_LOG2] ^ cur_y[TILE_LOG2]) ? ~bg_color : bg_color;
      2'd2:    bg_val = {cur_x[9:2], cur_y[8:1], bg_color[7:0]};
      default: bg_val = bg_color;
    endcase
    head.vld  = vld_in;
    head.sof  = sof;
    head.pix  = {r, g, b};
    head.pass = pass_in;
    head.bg   = bg_val;
    tail      = pipe[MIN_RUN-1];
    tail_rep  = rep_q[MIN_RUN-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      run_cnt <= '0;
    end else begin
      run_cnt <= run_next;
      if (vld_in) begin
        if (cur_x == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (cur_y == Y_LAST) ? cur_y : cur_y + YW'(1);
        end else begin
          x_cnt <= cur_x + XW'(1);
          y_cnt <= cur_y;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MIN_RUN; i++) pipe[i] <= '0;
      rep_q <= '0;
    end else begin
      pipe[0] <= head;
      for (int i = 1; i < MIN_RUN; i++) pipe[i] <= pipe[i-1];
      rep_q <= {rep_q[MIN_RUN-2:0] | {(MIN_RUN-1){trig}}, head_rep};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outR          <= '0;
      outG          <= '0;
      outB          <= '0;
      vld_out       <= 1'b0;
      sof_out       <= 1'b0;
      pass_thru     <= '0;
      key_count     <= '0;
      key_count_vld <= 1'b0;
      acc           <= '0;
    end else begin
      outR          <= tail_rep ? tail.bg[23:16] : tail.pix[23:16];
      outG          <= tail_rep ? tail.bg[15:8]  : tail.pix[15:8];
      outB          <= tail_rep ? tail.bg[7:0]   : tail.pix[7:0];
      vld_out       <= tail.vld;
      sof_out       <= tail.sof;
      pass_thru     <= tail.pass;
      key_count_vld <= 1'b0;
      if (tail.vld && tail.sof) begin
        key_count     <= acc;
        key_count_vld <= 1'b1;
        acc           <= {19'd0, tail_rep};
      end else if (tail.vld && tail_rep && acc != '1) begin
        acc <= acc + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_compositor.sv
// tb/tb_key_compositor.sv - scoreboard bench for key_compositor
module tb_key_compositor;
  localparam int H   = 8;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        comp_en = 1'b0;
  logic [7:0]  r = '0, g = '0, b = '0;
  logic        vld_in = 1'b0;
  logic        sof = 1'b0;
  logic [1:0]  bg_mode = '0;
  logic [23:0] bg_color = 24'h123456;
  logic [23:0] pass_in = '0;
  logic [7:0]  outR, outG, outB;
  logic        vld_out, sof_out, key_count_vld;
  logic [23:0] pass_thru;
  logic [19:0] key_count;

  key_compositor #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_RUN(4), .TILE_LOG2(1)) dut (
    .clk(clk), .rst(rst), .comp_en(comp_en), .r(r), .g(g), .b(b),
    .vld_in(vld_in), .sof(sof), .bg_mode(bg_mode), .bg_color(bg_color),
    .pass_in(pass_in), .outR(outR), .outG(outG), .outB(outB),
    .vld_out(vld_out), .sof_out(sof_out), .pass_thru(pass_thru),
    .key_count(key_count), .key_count_vld(key_count_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic [23:0] pass;
    logic        sof;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          kc_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  int          frame_cnt = 0;
  logic [23:0] line_pix [H];
  logic        line_en  [H];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard whenever a valid pixel emerges.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!rst) begin
      if (vld_out === 1'b1 || key_count_vld === 1'b1) begin
        vectors++;
        if (key_count_vld !== (vld_out & sof_out)) begin
          errors++;
          $display("FAIL kcv_align: key_count_vld=%b vld_out=%b sof_out=%b", key_count_vld, vld_out, sof_out);
        end
      end
      if (vld_out === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got %h at cycle %0d, none expected", {outR, outG, outB}, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({outR, outG, outB} !== e.pix || pass_thru !== e.pass || sof_out !== e.sof || cyc != e.cyc) begin
            errors++;
            $display("FAIL pixel: got pix=%h pass=%h sof=%b cyc=%0d, want pix=%h pass=%h sof=%b cyc=%0d",
                     {outR, outG, outB}, pass_thru, sof_out, cyc, e.pix, e.pass, e.sof, e.cyc);
          end
        end
      end
      if (key_count_vld === 1'b1) begin
        vectors++;
        if (kc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_kcv: key_count=%0d with no frame pending", key_count);
        end else begin
          k = kc_q.pop_front();
          if (key_count !== 20'(k)) begin
            errors++;
            $display("FAIL key_count: got %0d want %0d", key_count, k);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [23:0] p, input logic s, input logic en, input logic [1:0] mode,
                       input logic [23:0] exp_pix, input logic rep, input bit push);
    exp_t e;
    @(negedge clk);
    {r, g, b} = p;
    vld_in  = 1'b1;
    sof     = s;
    comp_en = en;
    bg_mode = mode;
    pass_in = 24'($urandom);
    if (push) begin
      e.pix  = exp_pix;
      e.pass = pass_in;
      e.sof  = s;
      e.cyc  = cyc + LAT;
      exp_q.push_back(e);
      if (s) begin
        kc_q.push_back(frame_cnt);
        frame_cnt = 0;
      end
      if (rep) frame_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vld_in = 1'b0;
      sof    = 1'b0;
    end
  endtask

  // Replacement model: a keyed pixel is replaced iff the maximal keyed
  // segment of its line containing it is at least 4 long.
  task automatic send_line(input bit first_sof, input logic [1:0] mode, input int y);
    logic        key [H];
    logic        rep;
    int          lo, hi;
    logic [23:0] bgv, ex;
    for (int i = 0; i < H; i++) key[i] = (line_pix[i] == 24'd0) && line_en[i] && (mode != 2'd3);
    for (int i = 0; i < H; i++) begin
      lo = i;
      while (lo > 0 && key[lo-1]) lo--;
      hi = i;
      while (hi < H - 1 && key[hi+1]) hi++;
      rep = key[i] && (hi - lo + 1 >= 4);
      case (mode)
        2'd1:    bgv = ((((i >> 1) ^ (y >> 1)) & 1) != 0) ? ~bg_color : bg_color;
        2'd2:    bgv = {8'(i >> 2), 8'(y >> 1), bg_color[7:0]};
        default: bgv = bg_color;
      endcase
      ex = rep ? bgv : line_pix[i];
      drive(line_pix[i], first_sof && (i == 0), line_en[i], mode, ex, rep, 1'b1);
    end
  endtask

  task automatic set_line(input logic [7:0] zero_mask);
    for (int i = 0; i < H; i++) begin
      line_pix[i] = zero_mask[7-i] ? 24'd0 : 24'($urandom_range(1, 24'hFFFFFF));
      line_en[i]  = 1'b1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || kc_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || kc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pixels and %0d counts still pending", exp_q.size(), kc_q.size());
    end
    idle(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({outR, outG, outB} !== 24'd0 || vld_out !== 1'b0 || sof_out !== 1'b0 || pass_thru !== 24'd0 ||
        key_count !== 20'd0 || key_count_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s: pix=%h vld=%b sof=%b pass=%h kc=%0d kcv=%b, want all zero",
               tag, {outR, outG, outB}, vld_out, sof_out, pass_thru, key_count, key_count_vld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      vectors++;
      if (vld_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_vld: got %b want 0", vld_out);
      end
    end
  endtask

  task automatic test_long_run();
    bg_mode = 2'd0;
    set_line(8'b1111_1000);
    send_line(1'b1, 2'd0, 0);
    idle(3);
  endtask

  task automatic test_short_run();
    set_line(8'b1110_1100);
    send_line(1'b1, 2'd0, 0);
    idle(3);
  endtask

  task automatic test_line_cross();
    set_line(8'b0000_0111);
    send_line(1'b1, 2'd0, 0);
    set_line(8'b1100_0000);
    send_line(1'b0, 2'd0, 1);
    idle(3);
  endtask

  task automatic test_comp_en_and_modes();
    set_line(8'hFF);
    for (int i = 2; i < H; i++) line_en[i] = 1'b0;
    send_line(1'b1, 2'd0, 0);
    set_line(8'hFF);
    send_line(1'b0, 2'd3, 1);
    set_line(8'hFF);
    send_line(1'b0, 2'd2, 2);
    idle(3);
  endtask

  task automatic test_checker();
    for (int y = 0; y < 4; y++) begin
      set_line(8'hFF);
      send_line(y == 0, 2'd1, y);
    end
    // Start of the next frame reports the 32 substitutions.
    set_line(8'h00);
    drive(line_pix[0], 1'b1, 1'b1, 2'd0, line_pix[0], 1'b0, 1'b1);
    idle(2);
    drain();
  endtask

  task automatic test_reset_mid_run();
    drive(24'd0, 1'b1, 1'b1, 2'd0, 24'd0, 1'b0, 1'b0);
    drive(24'd0, 1'b0, 1'b1, 2'd0, 24'd0, 1'b0, 1'b0);
    drive(24'd0, 1'b0, 1'b1, 2'd0, 24'd0, 1'b0, 1'b0);
    @(negedge clk);
    vld_in = 1'b0;
    sof    = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_mid_run");
    frame_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      vectors++;
      if (vld_out !== 1'b0 || key_count !== 20'd0) begin
        errors++;
        $display("FAIL post_reset_idle: vld_out=%b key_count=%0d want 0/0", vld_out, key_count);
      end
    end
    test_long_run();
    set_line(8'h00);
    drive(line_pix[0], 1'b1, 1'b1, 2'd0, line_pix[0], 1'b0, 1'b1);
    idle(2);
    drain();
  endtask

  initial begin
    test_reset();
    test_long_run();
    test_short_run();
    test_line_cross();
    test_comp_en_and_modes();
    test_checker();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
